// File: rtl/hd44780_pkg.sv
// Shared types, defaults and helpers for the HD44780 input scanner.
package hd44780_pkg;

  localparam int DEF_NUM_CH        = 8;
  localparam int DEF_SYNC_STAGES   = 2;
  localparam int DEF_STABLE_CYCLES = 48000;
  localparam int DEF_ALIVE_BITS    = 23;

  // Request handshake states: IDLE waits for a strobe, ACK drives the one-cycle acknowledge.
  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } scanState_t;

  // Width of a debounce counter able to hold 0..stableCycles.
  function automatic int CNT_W(input int stableCycles);
    return $clog2(stableCycles + 1);
  endfunction

endpackage

// File: rtl/hd44780_debounce_ch.sv
// One input channel: synchroniser chain, debounce counter, accepted level and edge pulses.
module hd44780_debounce_ch
  import hd44780_pkg::*;
#(
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_raw,
  output logic o_stable,
  output logic o_press,
  output logic o_release
);

  localparam int              CW         = CNT_W(STABLE_CYCLES);
  localparam logic [CW-1:0]   LAST_COUNT = CW'(STABLE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CW-1:0]          r_count;
  logic                   r_stable;
  logic                   r_press;
  logic                   r_release;

  logic w_sync;
  logic w_differs;
  logic w_accept;

  // The last flop of the chain is the only copy of the input the rest of the channel may use.
  assign w_sync    = r_sync[SYNC_STAGES-1];
  assign w_differs = (w_sync != r_stable);
  assign w_accept  = w_differs && (r_count == LAST_COUNT);

  // Shift the asynchronous input through the synchroniser chain.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
    end
  end

  // Count consecutive samples that disagree with the accepted level; accept on the last one.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count  <= '0;
      r_stable <= 1'b0;
    end else if (!w_differs) begin
      r_count <= '0;
    end else if (w_accept) begin
      r_stable <= w_sync;
      r_count  <= '0;
    end else begin
      r_count <= r_count + CW'(1);
    end
  end

  // Edge pulses are registered alongside the level flip so they line up with the new level.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_press   <= w_accept &  w_sync;
      r_release <= w_accept & ~w_sync;
    end
  end

  assign o_stable  = r_stable;
  assign o_press   = r_press;
  assign o_release = r_release;

endmodule

// File: rtl/hd44780_input_scanner.sv
// Multi-channel debounced input front end with a strobe/acknowledge state readout and alive blinker.
module hd44780_input_scanner
  import hd44780_pkg::*;
#(
  parameter int NUM_CH        = DEF_NUM_CH,
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int ALIVE_BITS    = DEF_ALIVE_BITS
) (
  input  logic              CLK_I,
  input  logic              RST_I,
  input  logic [NUM_CH-1:0] i_buttons,
  input  logic              STB_I,
  input  logic [NUM_CH-1:0] DAT_I,
  output logic              STB_O,
  output logic [NUM_CH-1:0] DAT_O,
  output logic [NUM_CH-1:0] o_press,
  output logic [NUM_CH-1:0] o_release,
  output logic              o_alive
);

  logic [NUM_CH-1:0] w_stable;
  logic [NUM_CH-1:0] w_press;
  logic [NUM_CH-1:0] w_release;

  scanState_t r_state;
  scanState_t w_nextState;
  logic       w_ack;

  logic              r_stbOut;
  logic [NUM_CH-1:0] r_datOut;
  logic [ALIVE_BITS-1:0] r_alive;

  // Every channel is an independent debouncer; any subset may flip on the same edge.
  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    hd44780_debounce_ch #(
      .SYNC_STAGES  (SYNC_STAGES),
      .STABLE_CYCLES(STABLE_CYCLES)
    ) u_ch (
      .i_clk    (CLK_I),
      .i_rst    (RST_I),
      .i_raw    (i_buttons[ch]),
      .o_stable (w_stable[ch]),
      .o_press  (w_press[ch]),
      .o_release(w_release[ch])
    );
  end

  // Handshake state register.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // ACK always returns to IDLE, so a held strobe is answered every second cycle.
  always_comb begin
    w_nextState = r_state;
    w_ack       = 1'b0;
    case (r_state)
      IDLE: begin
        if (STB_I) begin
          w_ack       = 1'b1;
          w_nextState = ACK;
        end
      end
      ACK: begin
        w_nextState = IDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Capture the pre-edge debounced state, so a coincident flip is only seen by the next request.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      r_stbOut <= 1'b0;
      r_datOut <= '0;
    end else begin
      r_stbOut <= w_ack;
      if (w_ack) begin
        r_datOut <= w_stable & DAT_I;
      end
    end
  end

  // Free-running blink counter; its MSB shows the clock is alive.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      r_alive <= '0;
    end else begin
      r_alive <= r_alive + ALIVE_BITS'(1);
    end
  end

  assign STB_O     = r_stbOut;
  assign DAT_O     = r_datOut;
  assign o_press   = w_press;
  assign o_release = w_release;
  assign o_alive   = r_alive[ALIVE_BITS-1];

endmodule

// File: tb/tb_hd44780_input_scanner.sv
// Self-checking bench for hd44780_input_scanner with a window-based reference model.
module tb_hd44780_input_scanner;

  localparam int NCH  = 4;
  localparam int SYNC = 2;
  localparam int STAB = 4;
  localparam int AB   = 4;

  logic           clk     = 1'b0;
  logic           rst     = 1'b1;
  logic [NCH-1:0] buttons = '0;
  logic           stbIn   = 1'b0;
  logic [NCH-1:0] datIn   = '0;
  logic           stbOut;
  logic [NCH-1:0] datOut;
  logic [NCH-1:0] pressOut;
  logic [NCH-1:0] relOut;
  logic           aliveOut;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state: inputs seen at each edge since reset, and expected outputs.
  logic [NCH-1:0] hist[$];
  int             edgeIdx  = 0;
  logic [NCH-1:0] mStable  = '0;
  logic [NCH-1:0] mPress   = '0;
  logic [NCH-1:0] mRelease = '0;
  logic [NCH-1:0] mDat     = '0;
  logic           mStb     = 1'b0;
  int             mAlive   = 0;

  always #5 clk = ~clk;

  hd44780_input_scanner #(
    .NUM_CH       (NCH),
    .SYNC_STAGES  (SYNC),
    .STABLE_CYCLES(STAB),
    .ALIVE_BITS   (AB)
  ) dut (
    .CLK_I    (clk),
    .RST_I    (rst),
    .i_buttons(buttons),
    .STB_I    (stbIn),
    .DAT_I    (datIn),
    .STB_O    (stbOut),
    .DAT_O    (datOut),
    .o_press  (pressOut),
    .o_release(relOut),
    .o_alive  (aliveOut)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic [NCH-1:0] b, input logic s, input logic [NCH-1:0] d);
    @(negedge clk);
    #1;
    buttons = b;
    stbIn   = s;
    datIn   = d;
  endtask

  task automatic afterEdges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic resetPulse(input string tag);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput({tag, "_stb"},   32'(stbOut),   32'd0);
    checkOutput({tag, "_dat"},   32'(datOut),   32'd0);
    checkOutput({tag, "_press"}, 32'(pressOut), 32'd0);
    checkOutput({tag, "_rel"},   32'(relOut),   32'd0);
    checkOutput({tag, "_alive"}, 32'(aliveOut), 32'd0);
    @(negedge clk);
    #1 rst = 1'b0;
  endtask

  // Model: a level is accepted when the last STAB synchronised samples all disagree with it.
  always @(posedge clk or posedge rst) begin : modelStep
    logic [NCH-1:0] prev;
    logic [NCH-1:0] next;
    bit             allDiff;
    logic           seen;
    int             j;
    if (rst) begin
      hist.delete();
      edgeIdx  = 0;
      mStable  = '0;
      mPress   = '0;
      mRelease = '0;
      mDat     = '0;
      mStb     = 1'b0;
      mAlive   = 0;
    end else begin
      prev = mStable;
      hist.push_back(buttons);
      for (int ch = 0; ch < NCH; ch++) begin
        allDiff = 1'b1;
        for (int k = 0; k < STAB; k++) begin
          j    = edgeIdx - k;
          seen = (j >= SYNC) ? hist[j - SYNC][ch] : 1'b0;
          if (seen == prev[ch]) allDiff = 1'b0;
        end
        next[ch] = allDiff ? ~prev[ch] : prev[ch];
      end
      mStable  = next;
      mPress   = next & ~prev;
      mRelease = ~next & prev;
      if (stbIn && !mStb) begin
        mStb = 1'b1;
        mDat = prev & datIn;
      end else begin
        mStb = 1'b0;
      end
      mAlive  = (mAlive + 1) % (1 << AB);
      edgeIdx = edgeIdx + 1;
    end
  end

  // Compare every output against the model in the middle of each cycle.
  always @(negedge clk) begin
    checkOutput("stb_o",   32'(stbOut),   32'(mStb));
    checkOutput("dat_o",   32'(datOut),   32'(mDat));
    checkOutput("press",   32'(pressOut), 32'(mPress));
    checkOutput("release", 32'(relOut),   32'(mRelease));
    checkOutput("alive",   32'(aliveOut), 32'((mAlive >> (AB - 1)) & 1));
  end

  initial begin : stimulus
    int pulses;

    // Power-up reset, then let the alive counter run.
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    afterEdges(8);
    checkOutput("alive_after8", 32'(aliveOut), 32'd1);
    afterEdges(8);
    checkOutput("alive_after16", 32'(aliveOut), 32'd0);
    afterEdges(8);
    checkOutput("alive_after24", 32'(aliveOut), 32'd1);

    // Asynchronous reset between edges clears everything; then a clean press on channel 0.
    resetPulse("rst_async");
    buttons = 4'b0001;
    afterEdges(5);
    checkOutput("press_edge4", 32'(pressOut), 32'd0);
    afterEdges(1);
    checkOutput("press_edge5", 32'(pressOut), 32'b0001);
    afterEdges(1);
    checkOutput("press_edge6", 32'(pressOut), 32'd0);

    // Release with the same latency.
    applyStimulus(4'b0000, 1'b0, '0);
    afterEdges(5);
    checkOutput("release_edge4", 32'(relOut), 32'd0);
    afterEdges(1);
    checkOutput("release_edge5", 32'(relOut), 32'b0001);
    afterEdges(1);
    checkOutput("release_edge6", 32'(relOut), 32'd0);

    // Bounce: three samples high on channel 1 must be rejected.
    applyStimulus(4'b0010, 1'b0, '0);
    afterEdges(3);
    applyStimulus(4'b0000, 1'b0, '0);
    for (int i = 0; i < 10; i++) begin
      afterEdges(1);
      checkOutput("bounce_no_press", 32'(pressOut), 32'd0);
    end
    applyStimulus(4'b0000, 1'b1, 4'b1111);
    afterEdges(1);
    checkOutput("bounce_req_stb", 32'(stbOut), 32'd1);
    checkOutput("bounce_req_dat", 32'(datOut), 32'd0);
    applyStimulus(4'b0000, 1'b0, '0);

    // Single request against stable state 1011.
    applyStimulus(4'b1011, 1'b0, '0);
    afterEdges(10);
    applyStimulus(4'b1011, 1'b1, 4'b0011);
    afterEdges(1);
    checkOutput("hs_stb_hi", 32'(stbOut), 32'd1);
    checkOutput("hs_dat",    32'(datOut), 32'b0011);
    applyStimulus(4'b1011, 1'b0, '0);
    afterEdges(1);
    checkOutput("hs_stb_lo",   32'(stbOut), 32'd0);
    checkOutput("hs_dat_hold", 32'(datOut), 32'b0011);
    afterEdges(2);

    // Strobe held for six sampled edges gives three acknowledges.
    applyStimulus(4'b1011, 1'b1, 4'b1111);
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      afterEdges(1);
      pulses += int'(stbOut);
    end
    applyStimulus(4'b1011, 1'b0, '0);
    afterEdges(1);
    pulses += int'(stbOut);
    checkOutput("held_acks", 32'(pulses), 32'd3);
    checkOutput("held_dat",  32'(datOut), 32'b1011);
    afterEdges(2);

    // Request at the same edge channel 2 flips 0->1 returns the old level.
    applyStimulus(4'b1111, 1'b0, '0);
    afterEdges(5);
    applyStimulus(4'b1111, 1'b1, 4'b1111);
    afterEdges(1);
    checkOutput("coinc_press", 32'(pressOut), 32'b0100);
    checkOutput("coinc_dat",   32'(datOut),   32'b1011);
    applyStimulus(4'b1111, 1'b0, '0);
    applyStimulus(4'b1111, 1'b1, 4'b1111);
    afterEdges(1);
    checkOutput("coinc_next_dat", 32'(datOut), 32'b1111);
    applyStimulus(4'b0000, 1'b0, '0);
    afterEdges(10);

    // Reset part-way through channel 3's count; the full latency applies afterwards.
    applyStimulus(4'b1000, 1'b0, '0);
    afterEdges(4);
    resetPulse("rst_midcount");
    afterEdges(5);
    checkOutput("mid_press_edge4", 32'(pressOut), 32'd0);
    afterEdges(1);
    checkOutput("mid_press_edge5", 32'(pressOut), 32'b1000);

    // Randomised traffic: sparse toggles produce a mix of accepted levels and rejected glitches.
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      #1;
      if ($urandom_range(0, 5) == 0) begin
        buttons = buttons ^ (NCH'(1) << $urandom_range(0, NCH - 1));
      end
      stbIn = ($urandom_range(0, 2) == 0);
      datIn = NCH'($urandom);
      if (i == 300) begin
        #1 rst = 1'b1;
        @(negedge clk);
        #1 rst = 1'b0;
      end
    end
    applyStimulus(buttons, 1'b0, '0);
    afterEdges(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
